// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared channel state encoding and divisor clamping for clkdiv_multi
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned clamp_div(input int unsigned div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divided-clock channel: counter, FSM, shadow divisor, CLKOUT/TICK registers
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_step,
    input  logic             i_sync,
    input  logic             i_div_we,
    input  logic [CNT_W-1:0] i_div_val,
    output logic             o_clkout,
    output logic             o_tick,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(clamp_div(DEFAULT_DIV));

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_clkout;
    logic             r_tick;
    logic             r_busy;

    logic [CNT_W-1:0] w_div_new;
    logic [CNT_W-1:0] w_div_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_hi;
    logic             w_boundary;
    logic             w_realign;
    logic             w_restart;

    assign w_div_new  = CNT_W'(clamp_div(32'(i_div_val)));
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_hi       = r_div - (r_div >> 1);
    assign w_boundary = (r_cnt == r_div - 1'b1);
    assign w_realign  = (r_state == ST_RUN) && i_sync;
    assign w_restart  = w_realign || ((r_state == ST_RUN) && i_enable);

    // A write landing on the boundary cycle wins over an older pending shadow.
    assign w_div_next = i_div_we  ? w_div_new :
                        r_pending ? r_shadow  : r_div;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div     <= RST_DIV;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_clkout  <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt    <= '0;
                    r_clkout <= 1'b0;
                    if (i_div_we) begin
                        r_div <= w_div_new;
                    end
                    if (i_enable || i_step) begin
                        r_state  <= i_enable ? ST_RUN : ST_STEP;
                        r_clkout <= 1'b1;
                        r_tick   <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (w_realign || w_boundary) begin
                        r_div     <= w_div_next;
                        r_pending <= 1'b0;
                        r_cnt     <= '0;
                        if (w_restart) begin
                            r_clkout <= 1'b1;
                            r_tick   <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_clkout <= 1'b0;
                            r_busy   <= 1'b0;
                        end
                    end else begin
                        r_cnt    <= w_cnt_inc;
                        r_clkout <= (w_cnt_inc < w_hi);
                        if (i_div_we) begin
                            r_shadow  <= w_div_new;
                            r_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_clkout <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_clkout = r_clkout;
    assign o_tick   = r_tick;
    assign o_busy   = r_busy;

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - N_CH programmable clock dividers; SYNC phase-align port present with CLKDIV_SYNC_EN
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 14,
    localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_CH-1:0]   ENABLE,
    input  logic [N_CH-1:0]   STEP,
    input  logic              DIV_WE,
    input  logic [SEL_W-1:0]  DIV_SEL,
    input  logic [CNT_W-1:0]  DIV_VAL,
`ifdef CLKDIV_SYNC_EN
    input  logic              SYNC,
`endif
    output logic [N_CH-1:0]   CLKOUT,
    output logic [N_CH-1:0]   TICK,
    output logic [N_CH-1:0]   BUSY
);

    logic w_sync;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = SYNC;
`else
    assign w_sync = 1'b0;
`endif

    // Selects that match no channel simply never raise a write enable.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic w_we;
        assign w_we = DIV_WE && (DIV_SEL == SEL_W'(gi));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .i_clk     (CLK),
            .i_rst     (RST),
            .i_enable  (ENABLE[gi]),
            .i_step    (STEP[gi]),
            .i_sync    (w_sync),
            .i_div_we  (w_we),
            .i_div_val (DIV_VAL),
            .o_clkout  (CLKOUT[gi]),
            .o_tick    (TICK[gi]),
            .o_busy    (BUSY[gi])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - directed bench for clkdiv_multi with a per-cycle period/position reference model
module tb_clkdiv_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int SEL_W = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [N_CH-1:0]  ENABLE;
    logic [N_CH-1:0]  STEP;
    logic             DIV_WE;
    logic [SEL_W-1:0] DIV_SEL;
    logic [CNT_W-1:0] DIV_VAL;
`ifdef CLKDIV_SYNC_EN
    logic             SYNC;
`endif
    logic [N_CH-1:0]  CLKOUT;
    logic [N_CH-1:0]  TICK;
    logic [N_CH-1:0]  BUSY;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    clkdiv_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(14)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ENABLE  (ENABLE),
        .STEP    (STEP),
        .DIV_WE  (DIV_WE),
        .DIV_SEL (DIV_SEL),
        .DIV_VAL (DIV_VAL),
`ifdef CLKDIV_SYNC_EN
        .SYNC    (SYNC),
`endif
        .CLKOUT  (CLKOUT),
        .TICK    (TICK),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each channel is either idle (pos=-1) or at position pos of a period of length per.
    int m_pos   [N_CH];
    int m_per   [N_CH];
    bit m_run   [N_CH];
    bit m_pend  [N_CH];
    int m_pendv [N_CH];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_CH; i++) begin
                m_pos[i]  = -1;
                m_per[i]  = 14;
                m_run[i]  = 1'b0;
                m_pend[i] = 1'b0;
                m_pendv[i] = 0;
            end
        end else begin
            bit s;
            int v;
            bit we;
            bit realign;
`ifdef CLKDIV_SYNC_EN
            s = SYNC;
`else
            s = 1'b0;
`endif
            v = int'(DIV_VAL);
            if (v < 2) v = 2;
            for (int i = 0; i < N_CH; i++) begin
                we = DIV_WE && (int'(DIV_SEL) == i);
                realign = m_run[i] && s;
                if (m_pos[i] < 0) begin
                    if (we) m_per[i] = v;
                    if (ENABLE[i] || STEP[i]) begin
                        m_pos[i] = 0;
                        m_run[i] = ENABLE[i];
                    end
                end else if (realign || m_pos[i] == m_per[i] - 1) begin
                    if (we) m_per[i] = v;
                    else if (m_pend[i]) m_per[i] = m_pendv[i];
                    m_pend[i] = 1'b0;
                    m_pos[i] = (realign || (m_run[i] && ENABLE[i])) ? 0 : -1;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                    if (we) begin
                        m_pend[i]  = 1'b1;
                        m_pendv[i] = v;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            for (int i = 0; i < N_CH; i++) begin
                int e_busy, e_clk, e_tick;
                e_busy = (m_pos[i] >= 0) ? 1 : 0;
                e_clk  = (e_busy == 1 && m_pos[i] < m_per[i] - m_per[i] / 2) ? 1 : 0;
                e_tick = (m_pos[i] == 0) ? 1 : 0;
                chk($sformatf("model clkout[%0d]", i), int'(CLKOUT[i]), e_clk);
                chk($sformatf("model tick[%0d]", i), int'(TICK[i]), e_tick);
                chk($sformatf("model busy[%0d]", i), int'(BUSY[i]), e_busy);
            end
        end
    end

    task automatic window(input string name, input int ch, input int n,
                          input int e_hi, input int e_tick, input int e_busy);
        int hi = 0;
        int tk = 0;
        int bz = 0;
        for (int k = 0; k < n; k++) begin
            hi += int'(CLKOUT[ch]);
            tk += int'(TICK[ch]);
            bz += int'(BUSY[ch]);
            @(negedge CLK);
        end
        chk({name, " high cycles"}, hi, e_hi);
        chk({name, " ticks"}, tk, e_tick);
        chk({name, " busy cycles"}, bz, e_busy);
    endtask

    task automatic wait_tick(input int ch);
        int k = 0;
        while (TICK[ch] !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk($sformatf("wait tick[%0d]", ch), int'(TICK[ch]), 1);
    endtask

    task automatic write_div(input int ch, input int val);
        DIV_WE  = 1'b1;
        DIV_SEL = SEL_W'(ch);
        DIV_VAL = CNT_W'(val);
        @(negedge CLK);
        DIV_WE  = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        ENABLE = '0;
        STEP = '0;
        DIV_WE = 1'b0;
        DIV_SEL = '0;
        DIV_VAL = '0;
`ifdef CLKDIV_SYNC_EN
        SYNC = 1'b0;
`endif
        @(negedge CLK);
        chk_on = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset clkout", int'(CLKOUT), 0);
        chk("reset busy", int'(BUSY), 0);

        // Default divisor 14 on channel 0
        ENABLE[0] = 1'b1;
        @(negedge CLK);
        chk("start tick0", int'(TICK[0]), 1);
        chk("start busy0", int'(BUSY[0]), 1);
        window("d14 p1", 0, 14, 7, 1, 14);
        window("d14 p2", 0, 14, 7, 1, 14);

        // D=5 loaded while idle
        write_div(1, 5);
        ENABLE[1] = 1'b1;
        @(negedge CLK);
        window("d5 p1", 1, 5, 3, 1, 5);
        window("d5 p2", 1, 10, 6, 2, 10);

        // Write landing on the boundary cycle (cnt=4 of D=5) applies immediately
        wait_tick(1);
        repeat (4) @(negedge CLK);
        write_div(1, 3);
        window("d3 boundary", 1, 3, 2, 1, 3);

        // D=0 clamps to 2
        write_div(2, 0);
        ENABLE[2] = 1'b1;
        @(negedge CLK);
        window("d2 p1", 2, 2, 1, 1, 2);
        window("d2 p3", 2, 6, 3, 3, 6);
        ENABLE[1] = 1'b0;
        ENABLE[2] = 1'b0;

        // Reload while running, last write wins; STEP in RUN ignored
        wait_tick(0);
        repeat (2) @(negedge CLK);
        STEP[0] = 1'b1;
        DIV_WE = 1'b1; DIV_SEL = 2'd0; DIV_VAL = 8'd9;
        @(negedge CLK);
        STEP[0] = 1'b0;
        DIV_VAL = 8'd6;
        @(negedge CLK);
        DIV_WE = 1'b0;
        window("reload rest", 0, 10, 3, 0, 10);
        window("reload d6 a", 0, 6, 3, 1, 6);
        window("reload d6 b", 0, 6, 3, 1, 6);

        // Async reset mid high phase
        wait_tick(0);
        #2 RST = 1'b1;
        #1;
        chk("async rst clkout", int'(CLKOUT), 0);
        chk("async rst tick", int'(TICK), 0);
        chk("async rst busy", int'(BUSY), 0);
        ENABLE = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ENABLE[0] = 1'b1;
        @(negedge CLK);
        window("post rst d14", 0, 14, 7, 1, 14);

        // ENABLE dropped at cnt=2: period completes, then idle
        ENABLE[3] = 1'b1;
        repeat (3) @(negedge CLK);
        ENABLE[3] = 1'b0;
        window("drop rest", 3, 12, 5, 0, 12);
        chk("drop idle busy", int'(BUSY[3]), 0);
        chk("drop idle clkout", int'(CLKOUT[3]), 0);

        // Single step: exactly one period
        STEP[3] = 1'b1;
        @(negedge CLK);
        STEP[3] = 1'b0;
        window("step period", 3, 14, 7, 1, 14);
        window("step after", 3, 14, 0, 0, 0);

`ifdef CLKDIV_SYNC_EN
        write_div(1, 4);
        write_div(2, 8);
        ENABLE[1] = 1'b1;
        repeat (3) @(negedge CLK);
        ENABLE[2] = 1'b1;
        repeat (2) @(negedge CLK);
        SYNC = 1'b1;
        @(negedge CLK);
        SYNC = 1'b0;
        chk("sync tick1", int'(TICK[1]), 1);
        chk("sync tick2", int'(TICK[2]), 1);
        begin
            int co = 0;
            for (int k = 0; k < 16; k++) begin
                co += int'(TICK[1] & TICK[2]);
                @(negedge CLK);
            end
            chk("sync coincident ticks", co, 2);
        end
`endif

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
